// File: rtl/seg_frame_pkg.sv
// Shared types and segment tables for the binary-to-7-segment frame generator.
package seg_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        ENCODE
    } state_t;

    localparam logic [7:0] SEG_DASH  = 8'h01;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int         DP_BIT    = 7;

    // MAX7219 no-decode layout: bit7 = DP, bits 6..0 = A..G
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
        8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        seg = SEG_BLANK;
        if (nib <= 4'd9) begin
            seg = SEG_DIGIT[nib];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd, bin} left.
module bcd_dabble_step #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [BIN_W-1:0]    bin_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [BIN_W-1:0]    bin_out
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
        {bcd_out, bin_out} = {adj[4*DIGITS-2:0], bin_in, 1'b0};
    end

endmodule

// File: rtl/seg_frame_gen.sv
// Binary value to MAX7219 no-decode segment frame via sequential double-dabble.
// Optional leading-zero blanking: define SEG_FRAME_GEN_LZ_BLANK_EN.
module seg_frame_gen
    import seg_frame_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              reset_sw,
    input  logic [BIN_W-1:0]  value,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              load,
    output logic              busy,
    output logic              frame_valid,
    output logic [7:0]        frame [DIGITS]
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] LIMIT = 64'(10 ** DIGITS) - 64'd1;

    state_t              state;
    state_t              state_nx;
    logic [BIN_W-1:0]    bin_q;
    logic [BIN_W-1:0]    bin_step;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_step;
    logic [DIGITS-1:0]   dp_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          frame_nx [DIGITS];

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_in  (bcd_q),
        .bin_in  (bin_q),
        .bcd_out (bcd_step),
        .bin_out (bin_step)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load) state_nx = CONVERT;
            CONVERT: if (cnt_q == CNT_W'(BIN_W - 1)) state_nx = ENCODE;
            ENCODE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // frame[0] takes the most-significant BCD nibble
    always_comb begin : encode_p
        logic [3:0] nib;
        logic [7:0] seg;
`ifdef SEG_FRAME_GEN_LZ_BLANK_EN
        logic       lead;
        lead = 1'b1;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_q[4*(DIGITS-1-i) +: 4];
            seg = seg_encode(nib);
`ifdef SEG_FRAME_GEN_LZ_BLANK_EN
            if (lead && nib == 4'd0 && i != DIGITS - 1) begin
                seg = SEG_BLANK;
            end else begin
                lead = 1'b0;
            end
`endif
            if (ovf_q) begin
                seg = SEG_DASH;
            end
            seg[DP_BIT] = dp_q[i];
            frame_nx[i] = seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sw) begin
            state       <= IDLE;
            frame_valid <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            dp_q        <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                frame[i] <= SEG_BLANK;
            end
        end else begin
            state       <= state_nx;
            frame_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        bin_q <= value;
                        dp_q  <= dp_mask;
                        bcd_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= (64'(value) > LIMIT);
                    end
                end
                CONVERT: begin
                    bin_q <= bin_step;
                    bcd_q <= bcd_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                ENCODE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        frame[i] <= frame_nx[i];
                    end
                    frame_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seg_frame_gen.md
Name: seg_frame_gen

Overview:
- Upstream feeder for max7219_display: converts a binary value into the 4-byte no-decode segment frame that max7219_display serialises to the MAX7219.
- Uses sequential double-dabble (shift-add-3) binary-to-BCD, then per-digit 7-segment encoding with a decimal-point mask.
- Replaces raw counter slices as the frame source in display designs.

Parameters:
- BIN_W, 14: width of the binary input; sets iteration count.
- DIGITS, 4: number of decimal digits and frame bytes. Overflow limit is 10^DIGITS-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_sw  in  1  synchronous, active-high reset.
- value  in  BIN_W  binary value to display; sampled on load.
- dp_mask  in  DIGITS  per-digit decimal point, bit i maps to frame[i]; sampled on load.
- load  in  1  request conversion; honoured only in IDLE.
- busy  out  1  high in CONVERT and ENCODE.
- frame_valid  out  1  one-cycle pulse when frame has been updated.
- frame  out  DIGITS x 8  unpacked [DIGITS] array of segment bytes; frame[0] = most-significant digit.

Behaviour:
- Interface (already decided): one clock `clk`; `reset_sw` is synchronous and active-high.
- Reset (any state, including mid-conversion):
  - state = IDLE; busy = 0; frame_valid = 0.
  - every frame byte = 8'h00 (blank).
  - An in-flight conversion is discarded.
- Segment byte format (MAX7219 no-decode): bit7 = DP, bits 6..0 = A B C D E F G.
  - 0..9 = 7E 30 6D 79 33 5B 5F 70 7F 7B.
  - dash = 01; blank = 00.
- FSM has states IDLE, CONVERT, ENCODE.
- IDLE:
  - On the edge where load = 1: capture value into the shift register, capture dp_mask, clear the BCD register (4*DIGITS bits) and the iteration counter. Next state is CONVERT.
- CONVERT: one iteration per cycle.
  - First, add 3 to each BCD nibble that is ≥ 5.
  - Then shift {bcd, bin} left by 1.
  - After BIN_W iterations, go to ENCODE.
- ENCODE: one cycle.
  - Register all frame bytes, pulse frame_valid, return to IDLE.
- Latency: frame and frame_valid change on edge BIN_W+1 after the load-capturing edge (edge 15 for defaults).
  - busy rises on the capture edge and falls on the same edge frame_valid rises.
- frame holds its value between updates. frame_valid lasts exactly one cycle.
- load while busy: ignored, with no queuing.
- load asserted on the cycle frame_valid is high: accepted, because the state is IDLE.
- Overflow: a captured value > 10^DIGITS-1 (e.g. > 9999) produces every byte = dash (01) with dp_mask still applied. The overflow check happens on the captured value.
- DP: frame[i][7] = dp_mask_captured[i] for every encoding (digit, blank, dash).
- Widths:
  - BCD nibbles are 4-bit, and add-3 never overflows a nibble.
  - The iteration counter is $clog2(BIN_W+1) bits.

Optional Feature:
- Macro: SEG_FRAME_GEN_LZ_BLANK_EN.
- Defined: leading-zero blanking. Digits before the first nonzero digit encode as 00, but frame[DIGITS-1] is never blanked (value 0 shows "   0"). DP bits are still applied to blanked digits. Overflow dashes are unaffected.
- Undefined: all digits are shown, including leading zeros (value 42 shows "0042").

Decomposition:
- Package seg_frame_pkg holds:
  - state enum (IDLE, CONVERT, ENCODE);
  - SEG_DASH, SEG_BLANK, DP_BIT constants;
  - SEG_DIGIT[10] lookup constant;
  - a function encoding a BCD nibble to a segment byte.
- One natural sub-module, bcd_dabble_step: combinational add-3-then-shift for one iteration, so the FSM only sequences it.

Test Plan:
- Reset, then load value=1234, dp_mask=0.
  - Expect busy=1 for 15 cycles.
  - Then frame = {30,6D,79,33} and a single frame_valid pulse on edge 15.
- load value=9999, dp_mask=4'b0100.
  - Expect frame = {7B,7B,FB,7B}.
  - Then load 10000: all bytes 01. Then load 16383: all bytes 01.
- load 42 with a second load of 7 asserted during busy.
  - Second load is ignored.
  - Frame shows 0042 = {7E,7E,33,6D} without LZ_BLANK_EN, and {00,00,33,6D} with it.
  - With the macro, load 0 yields {00,00,00,7E}.
- Assert reset_sw at CONVERT iteration 7 of a load 5678.
  - Next cycle: busy=0, frame all 00, no frame_valid pulse.
  - A following load 5678 yields {5B,5F,70,7F}.
- Back-to-back: load 1 held high continuously.
  - Conversions repeat every 16 cycles.
  - frame_valid pulses at edges 15, 31, 47.
  - frame stays stable {7E,7E,7E,30} between pulses.
